// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a write FIFO, configurable frame format and bit timing.
// The line output is registered from the current state, so it lags the FSM by one cycle.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  logic                 sysclk,
    input  logic                 cpu_resetn,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow,
    output logic                 busy,
    output logic                 uart_tx
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 push, pop, baud_end;

    assign full     = count_q == CNT_W'(FIFO_DEPTH);
    assign empty    = count_q == '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = state_q != S_IDLE;
    assign uart_tx  = tx_q;

    always_comb begin
        pop        = 1'b0;
        push       = wr_en && !full;
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        par_d      = par_q;
        tx_d       = 1'b1;
        baud_end   = baud_q == BAUD_W'(CLKS_PER_BIT - 1);
        baud_d     = (state_q == S_IDLE || baud_end) ? '0 : baud_q + BAUD_W'(1);
        overflow_d = overflow_q || (wr_en && full);
        case (state_q)
            S_IDLE: if (!empty) begin
                pop     = 1'b1;
                shift_d = fifo_mem[rd_ptr_q];
                par_d   = (PARITY == 1) ? ~^fifo_mem[rd_ptr_q] : ^fifo_mem[rd_ptr_q];
                bit_d   = '0;
                stop_d  = 1'b0;
                state_d = S_START;
            end
            S_START: begin
                tx_d    = 1'b0;
                state_d = baud_end ? S_DATA : S_START;
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(DATA_BITS - 1))
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                tx_d    = par_q;
                state_d = baud_end ? S_STOP : S_PAR;
            end
            S_STOP: if (baud_end) begin
                stop_d  = 1'b1;
                state_d = (stop_q == 1'(STOP_BITS - 1)) ? S_IDLE : S_STOP;
            end
            default: state_d = S_IDLE;
        endcase
        // A dropped write while full never reaches the pointers or the count.
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge sysclk) begin
        if (push) fifo_mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge sysclk) begin
        if (!cpu_resetn) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            shift_q    <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench over four parameterisations of uart_tx_fifo.
// A logger records the selected line every cycle; frames are checked cycle-exact against queued bytes.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_a, wr_a, full_a, empty_a, ovf_a, busy_a, tx_a;
    logic [7:0] data_a;
    logic [2:0] count_a;
    logic       rstn_b, wr_b, full_b, empty_b, ovf_b, busy_b, tx_b;
    logic [7:0] data_b;
    logic [2:0] count_b;
    logic       rstn_c, wr_c, full_c, empty_c, ovf_c, busy_c, tx_c;
    logic [7:0] data_c;
    logic [2:0] count_c;
    logic       rstn_d, wr_d, full_d, empty_d, ovf_d, busy_d, tx_d;
    logic [4:0] data_d;
    logic [2:0] count_d;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .CNT_W(3)) dut_a (
        .sysclk(clk), .cpu_resetn(rstn_a), .wr_en(wr_a), .wr_data(data_a), .full(full_a), .empty(empty_a),
        .count(count_a), .overflow(ovf_a), .busy(busy_a), .uart_tx(tx_a));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4), .CNT_W(3)) dut_b (
        .sysclk(clk), .cpu_resetn(rstn_b), .wr_en(wr_b), .wr_data(data_b), .full(full_b), .empty(empty_b),
        .count(count_b), .overflow(ovf_b), .busy(busy_b), .uart_tx(tx_b));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4), .CNT_W(3)) dut_c (
        .sysclk(clk), .cpu_resetn(rstn_c), .wr_en(wr_c), .wr_data(data_c), .full(full_c), .empty(empty_c),
        .count(count_c), .overflow(ovf_c), .busy(busy_c), .uart_tx(tx_c));
    uart_tx_fifo #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .CNT_W(3)) dut_d (
        .sysclk(clk), .cpu_resetn(rstn_d), .wr_en(wr_d), .wr_data(data_d), .full(full_d), .empty(empty_d),
        .count(count_d), .overflow(ovf_d), .busy(busy_d), .uart_tx(tx_d));

    int         passed = 0;
    int         total = 0;
    logic [1:0] sel = 2'd0;
    logic       tx_sel;
    logic       log_en = 1'b0;
    logic       track_en = 1'b0;
    logic       saw_full = 1'b0;
    int         maxc = 0;
    logic       txlog[$];
    logic [8:0] sbq[$];

    assign tx_sel = (sel == 2'd0) ? tx_a : (sel == 2'd1) ? tx_b : (sel == 2'd2) ? tx_c : tx_d;

    always @(posedge clk) begin
        #1;
        if (log_en) txlog.push_back(tx_sel);
        if (track_en) begin
            if (int'(count_a) > maxc) maxc = int'(count_a);
            if (full_a) saw_full = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic next_sample(output logic s, inout int budget);
        while (txlog.size() == 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        s = (txlog.size() > 0) ? txlog.pop_front() : 1'bx;
    endtask

    task automatic check_frame(input string tag, input int cpb, input int db, input int par,
                               input int sbits, input int exp_idle);
        logic [8:0]  d;
        logic [15:0] obs, expv;
        logic        s, lvl;
        int          idle, budget, nb;
        budget = 2000;
        idle = 0;
        d = (sbq.size() > 0) ? sbq.pop_front() : 9'bx;
        next_sample(s, budget);
        while (s === 1'b1) begin
            idle++;
            next_sample(s, budget);
        end
        chk({tag, " idle"}, idle, exp_idle);
        nb = 1 + db + ((par != 0) ? 1 : 0) + sbits;
        for (int b = 0; b < nb; b++) begin
            if (b == 0) lvl = 1'b0;
            else if (b <= db) lvl = d[b-1];
            else if (par != 0 && b == db + 1) lvl = (par == 1) ? ~^d : ^d;
            else lvl = 1'b1;
            obs = '0;
            expv = '0;
            for (int k = 0; k < cpb; k++) begin
                if (b != 0 || k != 0) next_sample(s, budget);
                obs[k] = s;
                expv[k] = lvl;
            end
            chk($sformatf("%s bit%0d", tag, b), obs, expv);
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        int lows;
        repeat (n) @(negedge clk);
        lows = 0;
        foreach (txlog[i]) if (txlog[i] !== 1'b1) lows++;
        txlog.delete();
        chk(tag, lows, 0);
    endtask

    initial begin
        {rstn_a, rstn_b, rstn_c, rstn_d} = '0;
        {wr_a, wr_b, wr_c, wr_d} = '0;
        data_a = '0; data_b = '0; data_c = '0; data_d = '0;
        repeat (2) @(negedge clk);
        chk("rst tx", tx_a, 1);
        chk("rst busy", busy_a, 0);
        chk("rst count", count_a, 0);
        chk("rst empty", empty_a, 1);
        chk("rst full", full_a, 0);
        chk("rst overflow", ovf_a, 0);
        chk("rst b tx", {tx_b, tx_c, tx_d}, 3'b111);
        {rstn_a, rstn_b, rstn_c, rstn_d} = '1;
        @(negedge clk);
        log_en = 1'b1;

        // single 0x55 frame, latency and busy fall
        sel = 2'd0;
        txlog.delete();
        wr_a = 1'b1; data_a = 8'h55; sbq.push_back(9'h055);
        @(negedge clk);
        wr_a = 1'b0;
        chk("t1 count1", count_a, 1);
        chk("t1 busy0", busy_a, 0);
        chk("t1 empty0", empty_a, 0);
        @(negedge clk);
        chk("t1 busy1", busy_a, 1);
        chk("t1 count0", count_a, 0);
        check_frame("t1", 4, 8, 0, 1, 2);
        chk("t1 busy end", busy_a, 0);
        chk("t1 empty end", empty_a, 1);

        // burst of four writes on a depth-4 FIFO
        @(negedge clk);
        txlog.delete();
        maxc = 0; saw_full = 1'b0; track_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_a = 1'b1; data_a = 8'(i); sbq.push_back(9'(i));
            @(negedge clk);
        end
        wr_a = 1'b0;
        check_frame("t3 f1", 4, 8, 0, 1, 2);
        check_frame("t3 f2", 4, 8, 0, 1, 1);
        check_frame("t3 f3", 4, 8, 0, 1, 1);
        check_frame("t3 f4", 4, 8, 0, 1, 1);
        track_en = 1'b0;
        chk("t3 peak count", maxc, 3);
        chk("t3 never full", saw_full, 0);

        // fill to full, then a dropped write sets overflow
        repeat (3) @(negedge clk);
        txlog.delete();
        for (int i = 0; i < 5; i++) begin
            wr_a = 1'b1; data_a = 8'hB0 + 8'(i); sbq.push_back(9'h0B0 + 9'(i));
            @(negedge clk);
        end
        chk("t4 full", full_a, 1);
        chk("t4 count4", count_a, 4);
        chk("t4 no ovf yet", ovf_a, 0);
        wr_a = 1'b1; data_a = 8'hAA;
        @(negedge clk);
        wr_a = 1'b0;
        chk("t4 ovf set", ovf_a, 1);
        chk("t4 count kept", count_a, 4);
        check_frame("t4 f0", 4, 8, 0, 1, 2);
        for (int i = 1; i < 5; i++) check_frame($sformatf("t4 f%0d", i), 4, 8, 0, 1, 1);
        chk("t4 ovf sticky", ovf_a, 1);
        chk("t4 empty", empty_a, 1);
        idle_check("t4 no extra frame", 50);

        // reset mid-frame with two queued entries
        wr_a = 1'b1; data_a = 8'h3C;
        @(negedge clk);
        data_a = 8'h11;
        @(negedge clk);
        data_a = 8'h22;
        @(negedge clk);
        wr_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5 busy pre", busy_a, 1);
        chk("t5 count pre", count_a, 2);
        rstn_a = 1'b0;
        @(negedge clk);
        chk("t5 tx", tx_a, 1);
        chk("t5 busy", busy_a, 0);
        chk("t5 count", count_a, 0);
        chk("t5 ovf", ovf_a, 0);
        chk("t5 empty", empty_a, 1);
        rstn_a = 1'b1;
        txlog.delete();
        idle_check("t5 silent", 100);

        // even parity with two stop bits
        sel = 2'd1;
        txlog.delete();
        wr_b = 1'b1; data_b = 8'h07; sbq.push_back(9'h007);
        @(negedge clk);
        data_b = 8'h0F; sbq.push_back(9'h00F);
        @(negedge clk);
        wr_b = 1'b0;
        check_frame("t2 even 07", 4, 8, 2, 2, 2);
        check_frame("t2 even 0F", 4, 8, 2, 2, 1);

        // odd parity
        @(negedge clk);
        sel = 2'd2;
        txlog.delete();
        wr_c = 1'b1; data_c = 8'h07; sbq.push_back(9'h007);
        @(negedge clk);
        data_c = 8'h0F; sbq.push_back(9'h00F);
        @(negedge clk);
        wr_c = 1'b0;
        check_frame("t2 odd 07", 4, 8, 1, 1, 2);
        check_frame("t2 odd 0F", 4, 8, 1, 1, 1);

        // 5-bit frames, write coincident with pop
        @(negedge clk);
        sel = 2'd3;
        txlog.delete();
        wr_d = 1'b1; data_d = 5'h01; sbq.push_back(9'h001);
        @(negedge clk);
        chk("t6 count1", count_d, 1);
        data_d = 5'h1F; sbq.push_back(9'h01F);
        @(negedge clk);
        wr_d = 1'b0;
        chk("t6 count steady", count_d, 1);
        chk("t6 busy", busy_d, 1);
        check_frame("t6 f01", 2, 5, 0, 1, 2);
        check_frame("t6 f1F", 2, 5, 0, 1, 1);
        chk("t6 empty", empty_d, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated write FIFO. It serialises CPU-written bytes onto `uart_tx`. It replaces the fixed 8N1 transmitter path behind the CPU wrapper with configurable frame format, bit timing and buffering. It runs entirely in the `sysclk` domain.

Parameters:
CLKS_PER_BIT, 868, sysclk cycles per UART bit (≥2); 868 gives 115200 baud at 100 MHz.
DATA_BITS, 8, payload bits per frame (5..9).
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame (1 or 2).
FIFO_DEPTH, 16, FIFO entries; must be a power of 2, ≥2.
CNT_W, 5, width of `count`; equals log2(FIFO_DEPTH)+1.

Ports:
sysclk  input  1  system clock; all logic is rising-edge.
cpu_resetn  input  1  reset; synchronous, active-low.
wr_en  input  1  push `wr_data` into the FIFO this cycle.
wr_data  input  DATA_BITS  payload to enqueue.
full  output  1  FIFO holds FIFO_DEPTH entries.
empty  output  1  FIFO holds 0 entries.
count  output  CNT_W  current FIFO occupancy.
overflow  output  1  sticky flag: a write was attempted while full.
busy  output  1  a frame is in progress (FSM not IDLE).
uart_tx  output  1  serial line; registered; idles high.

Behaviour:
- Reset (`cpu_resetn` low at a rising edge), applied on the next edge:
  - `uart_tx` = 1, `busy` = 0, `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0.
  - FIFO pointers are cleared and FSM = IDLE.
  - Reset mid-frame aborts the frame: the line returns high on that edge and buffered data is discarded.
- FIFO:
  - Circular buffer with read/write pointers. `full` and `empty` are decoded from the registered count.
  - A write when `full` = 1 is dropped, even if a pop occurs in the same cycle. It sets `overflow`, which stays set until reset.
  - A write when not full increments `count` on the next edge.
  - A simultaneous accepted write and pop leaves `count` unchanged; both pointers advance.
  - A write into an empty FIFO is visible to the FSM one cycle later (no write-through).
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `uart_tx` = 1. If `empty` = 0: pop the head into the shift register, compute parity, clear the bit counter and the baud counter, go to START.
  - START: `uart_tx` = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive shift-register bit 0 (LSB first) for CLKS_PER_BIT cycles, then shift right. After DATA_BITS bits, go to PARITY if PARITY ≠ 0, otherwise go to STOP.
  - PARITY: drive the parity bit for CLKS_PER_BIT cycles.
    - Even: XOR of the data bits.
    - Odd: inverted XOR of the data bits.
  - STOP: `uart_tx` = 1 for STOP_BITS × CLKS_PER_BIT cycles, then go to IDLE.
- Bit timing: the baud counter runs 0..CLKS_PER_BIT−1. Each bit level holds exactly CLKS_PER_BIT cycles; there is no cumulative drift.
- Latency: `wr_en` sampled at edge n with the FIFO empty and the FSM idle gives:
  - `count` = 1 after edge n.
  - Pop and START at edge n+1.
  - `uart_tx` low after edge n+2 (line output is registered).
- Back-to-back frames: the FSM leaves STOP and pops in IDLE on the following edge. The idle gap between a stop bit and the next start bit is exactly 1 cycle, in addition to the stop time.
- Frame length in cycles: (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) × CLKS_PER_BIT.
- `busy` = 1 in all states except IDLE.
- Unused upper bits of `wr_data` do not exist; the width equals DATA_BITS.

Test Plan:
1. CLKS_PER_BIT = 4, DATA_BITS = 8, PARITY = 0, STOP_BITS = 1. Single write 0x55 → `uart_tx` low 2 cycles after the write edge. The line then carries 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), 4 cycles per bit, 40 cycles total. `busy` falls after the stop bit.
2. PARITY = 2, then PARITY = 1, write 0x07 → 8 data bits, then parity bit 1 (even) or 0 (odd), then stop. STOP_BITS = 2 holds the line high 8 cycles.
3. FIFO_DEPTH = 4, write 0x01..0x04 on consecutive cycles while idle → the first pop happens mid-burst. `count` peaks at 3, `full` never asserts. Four frames go out in order with a 1-cycle gap between frames.
4. Fill to `full` (hold the FSM busy), then write 0xAA → data dropped, `overflow` = 1 and stays 1. Transmitted sequence excludes 0xAA. `empty` = 1 after the last pop.
5. Assert `cpu_resetn` = 0 during the DATA state of frame 0x3C with 2 queued entries → on the next edge `uart_tx` = 1, `busy` = 0, `count` = 0, `overflow` = 0. No further frames are sent after release.
6. DATA_BITS = 5, CLKS_PER_BIT = 2, write 0x1F at the same edge the FIFO pops (count steady) → `count` unchanged that cycle. Frame is 7 bits × 2 cycles; the data portion is 5 ones.
